// File: rtl/rv_dmem_responder.sv
// -----------------------------------------------------------------------------
// rv_dmem_responder
//
// Data-memory responder for the single-cycle RV32I core. Serves combinational
// word reads, commits byte/half/word stores on the rising clock edge with byte
// lane steering, and exposes a small MMIO page used by the verification
// platform (tohost/test-done, a cycle counter and a saturating store counter).
// Misaligned stores and unmapped accesses raise sticky error flags.
//
// Optional feature macro: RV_DMEM_CONSOLE_EN
//   When defined, a write-only console register appears at MMIO offset 0xC and
//   the ports console_valid / console_byte are added. When undefined, offset
//   0xC is unmapped and those ports do not exist.
//
// Ports:
//   clk             clock
//   rst             synchronous, active-high reset (control state only)
//   memory_address  byte address from the core
//   data_to_write   store data, right-justified (unshifted rs2)
//   func3           access size: 000 byte, 001 half, 010 word
//   write_data      store request, sampled at posedge clk
//   read_data       aligned 32-bit word containing memory_address
//   test_done       set by the first word store to tohost
//   test_code       value of that first tohost store
//   cycle_count     cycles since reset deassertion (wraps)
//   store_count     accepted stores, saturating at 16'hFFFF
//   misaligned_err  sticky misaligned-store flag
//   unmapped_err    sticky unmapped-access flag
//   console_valid   (RV_DMEM_CONSOLE_EN) one-cycle pulse per console write
//   console_byte    (RV_DMEM_CONSOLE_EN) byte carried by the pulse
// -----------------------------------------------------------------------------
module rv_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] memory_address,
    input  logic [31:0] data_to_write,
    input  logic [2:0]  func3,
    input  logic        write_data,
    output logic [31:0] read_data,
    output logic        test_done,
    output logic [31:0] test_code,
    output logic [31:0] cycle_count,
    output logic [15:0] store_count,
    output logic        misaligned_err,
    output logic        unmapped_err
`ifdef RV_DMEM_CONSOLE_EN
    ,
    output logic        console_valid,
    output logic [7:0]  console_byte
`endif
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // RAM is data: never reset, zero at time 0.
    logic [31:0] mem [DEPTH_WORDS] = '{default: 32'd0};

    logic [IDX_W-1:0] ram_idx;
    logic [29:0]      mmio_woff;
    logic             is_ram;
    logic             is_page;
    logic             sel_tohost;
    logic             sel_cycle;
    logic             sel_stcnt;
    logic             mapped;
`ifdef RV_DMEM_CONSOLE_EN
    logic             sel_console;
`endif

    // Store decode results
    logic [3:0]  byte_en;
    logic [31:0] wr_lanes;
    logic        accept;
    logic        tohost_wr;
    logic        set_mis;
    logic        set_unm;
    logic        size_ok;
    logic        aligned;
`ifdef RV_DMEM_CONSOLE_EN
    logic        console_wr;
`endif

    // ---- address decode ----------------------------------------------------
    // Word offset into the MMIO page computed on word addresses so that the
    // page test is a simple "upper bits are zero" check and wraps cleanly.
    assign ram_idx    = memory_address[IDX_W+1:2];
    assign mmio_woff  = memory_address[31:2] - MMIO_BASE[31:2];
    assign is_ram     = {memory_address[31:2], 2'b00} < RAM_BYTES;
    assign is_page    = (mmio_woff[29:2] == 28'd0) && !is_ram;
    assign sel_tohost = is_page && (mmio_woff[1:0] == 2'd0);
    assign sel_cycle  = is_page && (mmio_woff[1:0] == 2'd1);
    assign sel_stcnt  = is_page && (mmio_woff[1:0] == 2'd2);
`ifdef RV_DMEM_CONSOLE_EN
    assign sel_console = is_page && (mmio_woff[1:0] == 2'd3);
    assign mapped      = is_ram || sel_tohost || sel_cycle || sel_stcnt || sel_console;
`else
    assign mapped      = is_ram || sel_tohost || sel_cycle || sel_stcnt;
`endif

    // ---- read path (combinational, full aligned word) ----------------------
    always_comb begin
        read_data = 32'd0;
        if (is_ram)
            read_data = mem[ram_idx];
        else if (sel_tohost)
            read_data = test_code;
        else if (sel_cycle)
            read_data = cycle_count;
        else if (sel_stcnt)
            read_data = {16'd0, store_count};
    end

    // ---- store decode ------------------------------------------------------
    always_comb begin
        byte_en   = 4'b0000;
        wr_lanes  = 32'd0;
        accept    = 1'b0;
        tohost_wr = 1'b0;
        set_mis   = 1'b0;
        set_unm   = 1'b0;
        size_ok   = 1'b1;
        aligned   = 1'b1;
`ifdef RV_DMEM_CONSOLE_EN
        console_wr = 1'b0;
`endif

        case (func3)
            F3_SB: aligned = 1'b1;
            F3_SH: aligned = !memory_address[0];
            F3_SW: aligned = (memory_address[1:0] == 2'b00);
            default: size_ok = 1'b0;
        endcase

        if (write_data) begin
            if (!size_ok) begin
                set_unm = 1'b1;
            end else if (!aligned) begin
                set_mis = 1'b1;
            end else if (is_ram) begin
                accept = 1'b1;
                // Replicate the source bytes across lanes; byte_en picks the
                // lane(s) that actually land.
                case (func3)
                    F3_SB: begin
                        wr_lanes = {4{data_to_write[7:0]}};
                        byte_en  = 4'b0001 << memory_address[1:0];
                    end
                    F3_SH: begin
                        wr_lanes = {2{data_to_write[15:0]}};
                        byte_en  = memory_address[1] ? 4'b1100 : 4'b0011;
                    end
                    default: begin
                        wr_lanes = data_to_write;
                        byte_en  = 4'b1111;
                    end
                endcase
            end else if (sel_tohost && (func3 == F3_SW)) begin
                accept    = 1'b1;
                tohost_wr = 1'b1;
            end
`ifdef RV_DMEM_CONSOLE_EN
            else if (sel_console && (func3 != F3_SH)) begin
                accept     = 1'b1;
                console_wr = 1'b1;
            end
`endif
            else begin
                set_unm = 1'b1;
            end
        end else if (!mapped) begin
            set_unm = 1'b1;
        end
    end

    // ---- RAM commit (not reset; a store coincident with rst is dropped) ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b])
                    mem[ram_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    // ---- control / MMIO state ----------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            test_done      <= 1'b0;
            test_code      <= 32'd0;
            cycle_count    <= 32'd0;
            store_count    <= 16'd0;
            misaligned_err <= 1'b0;
            unmapped_err   <= 1'b0;
`ifdef RV_DMEM_CONSOLE_EN
            console_valid  <= 1'b0;
            console_byte   <= 8'd0;
`endif
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (accept && (store_count != 16'hFFFF))
                store_count <= store_count + 16'd1;
            // First tohost write wins; later ones are accepted but ignored.
            if (tohost_wr && !test_done) begin
                test_done <= 1'b1;
                test_code <= data_to_write;
            end
            if (set_mis)
                misaligned_err <= 1'b1;
            if (set_unm)
                unmapped_err <= 1'b1;
`ifdef RV_DMEM_CONSOLE_EN
            console_valid <= console_wr;
            if (console_wr)
                console_byte <= data_to_write[7:0];
`endif
        end
    end

endmodule

// File: tb/tb_rv_dmem_responder.sv
// -----------------------------------------------------------------------------
// Directed testbench for rv_dmem_responder. Each scenario task drives its own
// stimulus and checks results inline against hand-computed values.
// -----------------------------------------------------------------------------
module tb_rv_dmem_responder;

    localparam logic [31:0] MMIO = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] memory_address;
    logic [31:0] data_to_write;
    logic [2:0]  func3;
    logic        write_data;
    logic [31:0] read_data;
    logic        test_done;
    logic [31:0] test_code;
    logic [31:0] cycle_count;
    logic [15:0] store_count;
    logic        misaligned_err;
    logic        unmapped_err;
`ifdef RV_DMEM_CONSOLE_EN
    logic        console_valid;
    logic [7:0]  console_byte;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rv_dmem_responder #(.DEPTH_WORDS(1024), .MMIO_BASE(MMIO)) dut (
        .clk            (clk),
        .rst            (rst),
        .memory_address (memory_address),
        .data_to_write  (data_to_write),
        .func3          (func3),
        .write_data     (write_data),
        .read_data      (read_data),
        .test_done      (test_done),
        .test_code      (test_code),
        .cycle_count    (cycle_count),
        .store_count    (store_count),
        .misaligned_err (misaligned_err),
        .unmapped_err   (unmapped_err)
`ifdef RV_DMEM_CONSOLE_EN
        ,
        .console_valid  (console_valid),
        .console_byte   (console_byte)
`endif
    );

    // Idle bus: word read of address 0 (mapped RAM, never flags an error).
    task automatic bus_idle();
        memory_address = 32'd0;
        data_to_write  = 32'd0;
        func3          = 3'b010;
        write_data     = 1'b0;
    endtask

    // One store transaction; returns 1 time unit after the committing edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        @(negedge clk);
        memory_address = a;
        data_to_write  = d;
        func3          = f;
        write_data     = 1'b1;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic read_word(input logic [31:0] a, output logic [31:0] v);
        memory_address = a;
        #1;
        v = read_data;
        memory_address = 32'd0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (test_done !== 1'b0) $display("FAIL reset_test_done: got %0b want 0", test_done); else n_pass++;
        n_checks++; if (test_code !== 32'd0) $display("FAIL reset_test_code: got %h want 0", test_code); else n_pass++;
        n_checks++; if (cycle_count !== 32'd0) $display("FAIL reset_cycle_count: got %h want 0", cycle_count); else n_pass++;
        n_checks++; if (store_count !== 16'd0) $display("FAIL reset_store_count: got %h want 0", store_count); else n_pass++;
        n_checks++; if (misaligned_err !== 1'b0) $display("FAIL reset_misaligned: got %0b want 0", misaligned_err); else n_pass++;
        n_checks++; if (unmapped_err !== 1'b0) $display("FAIL reset_unmapped: got %0b want 0", unmapped_err); else n_pass++;
        n_checks++; if (read_data !== 32'd0) $display("FAIL reset_ram_zero: got %h want 0", read_data); else n_pass++;
    endtask

    task automatic test_cycle_count();
        logic [31:0] v;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (cycle_count !== 32'd10) $display("FAIL cycle_after_10: got %0d want 10", cycle_count); else n_pass++;
        read_word(MMIO + 32'h4, v);
        n_checks++; if (v !== 32'd10) $display("FAIL cycle_mmio_read: got %0d want 10", v); else n_pass++;
    endtask

    task automatic test_word_byte();
        logic [31:0] v;
        store(32'h10, 32'hDEAD_BEEF, 3'b010);
        store(32'h12, 32'h0000_0055, 3'b000);
        read_word(32'h10, v);
        n_checks++; if (v !== 32'hDE55_BEEF) $display("FAIL sb_merge: got %h want de55beef", v); else n_pass++;
        n_checks++; if (store_count !== 16'd2) $display("FAIL store_count_2: got %0d want 2", store_count); else n_pass++;
        read_word(32'h13, v);
        n_checks++; if (v !== 32'hDE55_BEEF) $display("FAIL unaligned_read: got %h want de55beef", v); else n_pass++;
        // Read during a store to the same word sees the old value.
        @(negedge clk);
        memory_address = 32'h10;
        data_to_write  = 32'h1234_5678;
        func3          = 3'b010;
        write_data     = 1'b1;
        #1;
        n_checks++; if (read_data !== 32'hDE55_BEEF) $display("FAIL read_during_store: got %h want de55beef", read_data); else n_pass++;
        @(posedge clk);
        #1;
        write_data = 1'b0;
        #1;
        n_checks++; if (read_data !== 32'h1234_5678) $display("FAIL read_after_store: got %h want 12345678", read_data); else n_pass++;
        bus_idle();
    endtask

    task automatic test_half();
        logic [31:0] v;
        store(32'h20, 32'h1122_3344, 3'b010);
        store(32'h22, 32'h0000_A5A5, 3'b001);
        read_word(32'h20, v);
        n_checks++; if (v !== 32'hA5A5_3344) $display("FAIL sh_upper: got %h want a5a53344", v); else n_pass++;
        store(32'h20, 32'hFFFF_5A5A, 3'b001);
        read_word(32'h20, v);
        n_checks++; if (v !== 32'hA5A5_5A5A) $display("FAIL sh_lower: got %h want a5a55a5a", v); else n_pass++;
        n_checks++; if (misaligned_err !== 1'b0) $display("FAIL mis_before: got %0b want 0", misaligned_err); else n_pass++;
        store(32'h23, 32'h0000_BBBB, 3'b001);
        n_checks++; if (misaligned_err !== 1'b1) $display("FAIL sh_misaligned_flag: got %0b want 1", misaligned_err); else n_pass++;
        read_word(32'h20, v);
        n_checks++; if (v !== 32'hA5A5_5A5A) $display("FAIL sh_misaligned_nowrite: got %h want a5a55a5a", v); else n_pass++;
        n_checks++; if (store_count !== 16'd6) $display("FAIL store_count_6: got %0d want 6", store_count); else n_pass++;
        n_checks++; if (unmapped_err !== 1'b0) $display("FAIL unm_after_half: got %0b want 0", unmapped_err); else n_pass++;
    endtask

    task automatic test_tohost();
        logic [31:0] v;
        n_checks++; if (test_done !== 1'b0) $display("FAIL tohost_before: got %0b want 0", test_done); else n_pass++;
        store(MMIO, 32'h1, 3'b010);
        store(MMIO, 32'h2, 3'b010);
        n_checks++; if (test_done !== 1'b1) $display("FAIL tohost_done: got %0b want 1", test_done); else n_pass++;
        n_checks++; if (test_code !== 32'h1) $display("FAIL tohost_first_wins: got %h want 1", test_code); else n_pass++;
        read_word(MMIO, v);
        n_checks++; if (v !== 32'h1) $display("FAIL tohost_read: got %h want 1", v); else n_pass++;
        read_word(MMIO + 32'h8, v);
        n_checks++; if (v !== 32'd8) $display("FAIL stcnt_read: got %h want 8", v); else n_pass++;
        n_checks++; if (unmapped_err !== 1'b0) $display("FAIL tohost_no_err: got %0b want 0", unmapped_err); else n_pass++;
    endtask

    task automatic test_unmapped();
        logic [31:0] v;
        store(32'h4000_0000, 32'hCAFE_F00D, 3'b010);
        n_checks++; if (unmapped_err !== 1'b1) $display("FAIL unmapped_store_flag: got %0b want 1", unmapped_err); else n_pass++;
        n_checks++; if (store_count !== 16'd8) $display("FAIL unmapped_not_counted: got %0d want 8", store_count); else n_pass++;
        read_word(32'h0, v);
        n_checks++; if (v !== 32'd0) $display("FAIL unmapped_ram_alias: got %h want 0", v); else n_pass++;
        read_word(32'h4000_0000, v);
        n_checks++; if (v !== 32'd0) $display("FAIL unmapped_read_zero: got %h want 0", v); else n_pass++;
        // RAM survives reset.
        pulse_reset();
        read_word(32'h10, v);
        n_checks++; if (v !== 32'h1234_5678) $display("FAIL ram_survives_reset: got %h want 12345678", v); else n_pass++;
    endtask

    // Each row is one error source that must set only unmapped_err.
    task automatic test_error_sources();
        logic [31:0] addrs [6];
        logic [2:0]  f3s   [6];
        logic        wrs   [6];
        logic [31:0] v;
        addrs = '{MMIO + 32'h4, MMIO + 32'h8, MMIO, MMIO, 32'h30, 32'h4000_0000};
        f3s   = '{3'b010, 3'b010, 3'b000, 3'b001, 3'b011, 3'b010};
        wrs   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            pulse_reset();
            @(negedge clk);
            memory_address = addrs[i];
            data_to_write  = 32'h0000_0077;
            func3          = f3s[i];
            write_data     = wrs[i];
            #1;
            n_checks++; if (unmapped_err !== 1'b0) $display("FAIL err_src%0d_before_edge: got %0b want 0", i, unmapped_err); else n_pass++;
            @(posedge clk);
            #1;
            bus_idle();
            n_checks++; if (unmapped_err !== 1'b1) $display("FAIL err_src%0d_flag: got %0b want 1", i, unmapped_err); else n_pass++;
            n_checks++; if (store_count !== 16'd0) $display("FAIL err_src%0d_count: got %0d want 0", i, store_count); else n_pass++;
            n_checks++; if (test_done !== 1'b0) $display("FAIL err_src%0d_done: got %0b want 0", i, test_done); else n_pass++;
        end
        read_word(32'h30, v);
        n_checks++; if (v !== 32'd0) $display("FAIL bad_func3_nowrite: got %h want 0", v); else n_pass++;
        // Flag stays set while the bus idles on mapped addresses.
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (unmapped_err !== 1'b1) $display("FAIL unmapped_sticky: got %0b want 1", unmapped_err); else n_pass++;
    endtask

    task automatic test_reset_priority();
        logic [31:0] v;
        store(MMIO, 32'h99, 3'b010);
        store(32'h1, 32'h0, 3'b010);
        @(negedge clk);
        rst            = 1'b1;
        memory_address = 32'h0;
        data_to_write  = 32'hBADC_0DE5;
        func3          = 3'b010;
        write_data     = 1'b1;
        @(posedge clk);
        #1;
        bus_idle();
        read_word(32'h0, v);
        n_checks++; if (v !== 32'd0) $display("FAIL rstprio_ram: got %h want 0", v); else n_pass++;
        n_checks++; if (test_done !== 1'b0) $display("FAIL rstprio_done: got %0b want 0", test_done); else n_pass++;
        n_checks++; if (test_code !== 32'd0) $display("FAIL rstprio_code: got %h want 0", test_code); else n_pass++;
        n_checks++; if (cycle_count !== 32'd0) $display("FAIL rstprio_cycle: got %h want 0", cycle_count); else n_pass++;
        n_checks++; if (store_count !== 16'd0) $display("FAIL rstprio_stcnt: got %h want 0", store_count); else n_pass++;
        n_checks++; if (misaligned_err !== 1'b0) $display("FAIL rstprio_mis: got %0b want 0", misaligned_err); else n_pass++;
        n_checks++; if (unmapped_err !== 1'b0) $display("FAIL rstprio_unm: got %0b want 0", unmapped_err); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wrap_saturate();
        @(negedge clk);
        force dut.cycle_count = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_count;
        @(posedge clk);
        #1;
        n_checks++; if (cycle_count !== 32'hFFFF_FFFF) $display("FAIL cycle_pre_wrap: got %h want ffffffff", cycle_count); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (cycle_count !== 32'd0) $display("FAIL cycle_wrap: got %h want 0", cycle_count); else n_pass++;
        @(negedge clk);
        force dut.store_count = 16'hFFFE;
        #1;
        release dut.store_count;
        store(32'h40, 32'h1, 3'b010);
        n_checks++; if (store_count !== 16'hFFFF) $display("FAIL stcnt_reach_max: got %h want ffff", store_count); else n_pass++;
        store(32'h40, 32'h2, 3'b010);
        n_checks++; if (store_count !== 16'hFFFF) $display("FAIL stcnt_saturate: got %h want ffff", store_count); else n_pass++;
    endtask

`ifdef RV_DMEM_CONSOLE_EN
    task automatic test_console();
        pulse_reset();
        store(MMIO + 32'hC, 32'h0000_0041, 3'b000);
        n_checks++; if (console_valid !== 1'b1) $display("FAIL con_valid: got %0b want 1", console_valid); else n_pass++;
        n_checks++; if (console_byte !== 8'h41) $display("FAIL con_byte: got %h want 41", console_byte); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (console_valid !== 1'b0) $display("FAIL con_one_cycle: got %0b want 0", console_valid); else n_pass++;
        store(MMIO + 32'hC, 32'h1234_5642, 3'b010);
        n_checks++; if (console_valid !== 1'b1 || console_byte !== 8'h42) $display("FAIL con_b2b_first: got %0b/%h want 1/42", console_valid, console_byte); else n_pass++;
        store(MMIO + 32'hC, 32'h0000_0043, 3'b000);
        n_checks++; if (console_valid !== 1'b1 || console_byte !== 8'h43) $display("FAIL con_b2b_second: got %0b/%h want 1/43", console_valid, console_byte); else n_pass++;
        n_checks++; if (store_count !== 16'd3) $display("FAIL con_counted: got %0d want 3", store_count); else n_pass++;
        n_checks++; if (unmapped_err !== 1'b0) $display("FAIL con_no_err: got %0b want 0", unmapped_err); else n_pass++;
        store(MMIO + 32'hC, 32'h0000_0044, 3'b001);
        n_checks++; if (console_valid !== 1'b0) $display("FAIL con_sh_no_pulse: got %0b want 0", console_valid); else n_pass++;
        n_checks++; if (unmapped_err !== 1'b1) $display("FAIL con_sh_err: got %0b want 1", unmapped_err); else n_pass++;
    endtask
`else
    task automatic test_console();
        pulse_reset();
        store(MMIO + 32'hC, 32'h0000_0041, 3'b000);
        n_checks++; if (unmapped_err !== 1'b1) $display("FAIL con_off_unmapped: got %0b want 1", unmapped_err); else n_pass++;
        n_checks++; if (store_count !== 16'd0) $display("FAIL con_off_count: got %0d want 0", store_count); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_cycle_count();
        test_word_byte();
        test_half();
        test_tohost();
        test_unmapped();
        test_error_sources();
        test_reset_priority();
        test_wrap_saturate();
        test_console();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
